// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch predictor types and constants
package bp_pkg;

   localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

   localparam logic [1:0] SEL_STRONG_P1 = 2'd0;
   localparam logic [1:0] SEL_WEAK_P1   = 2'd1;
   localparam logic [1:0] SEL_WEAK_P2   = 2'd2;
   localparam logic [1:0] SEL_STRONG_P2 = 2'd3;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } chooser_state_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter update cell
module sat_counter2 (
   input  logic [1:0] cnt,
   input  logic       inc,
   input  logic       dec,
   output logic [1:0] cnt_next
);

   // step toward 3 on inc, toward 0 on dec; conflicting or idle requests hold
   always_comb begin
      cnt_next = cnt;
      if (inc && !dec && cnt != 2'd3) begin
         cnt_next = cnt + 2'd1;
      end else if (dec && !inc && cnt != 2'd0) begin
         cnt_next = cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_chooser.sv
// rtl/branch_chooser.sv - tournament chooser table selecting between two predictors
module branch_chooser
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         fetch_pc,
   input  logic                predict1,
   input  logic                predict2,
   output logic                pprediction,
   output logic                use_p2,
   input  logic                upd_valid,
   input  logic [31:0]         upd_pc,
   input  logic                taken1,
   input  logic                taken2,
   input  logic                true_in,
   output logic                ready,
   output logic [CNT_BITS-1:0] mispredict_count
);

   localparam int DEPTH = 1 << IDX_BITS;

   chooser_state_t      state;
   chooser_state_t      state_next;
   logic [IDX_BITS-1:0] init_idx;
   logic [1:0]          sel_tbl [DEPTH];

   logic [IDX_BITS-1:0] look_idx;
   logic [IDX_BITS-1:0] upd_idx;
   logic [1:0]          sel;
   logic [1:0]          upd_cur;
   logic [1:0]          upd_next;
   logic                init_we;
   logic                upd_we;
   logic                miss_inc;
   logic                unused_bits;

   // PC word index selects the entry; upper PC bits alias by design (no tags)
   assign look_idx = fetch_pc[IDX_BITS+1:2];
   assign upd_idx  = upd_pc[IDX_BITS+1:2];
   assign sel      = sel_tbl[look_idx];
   assign upd_cur  = sel_tbl[upd_idx];

   assign unused_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                          upd_pc[31:IDX_BITS+2], upd_pc[1:0], sel[0]};

   // lookup reads the pre-update table, so a same-cycle write is seen next cycle
   assign use_p2      = ready & sel[1];
   assign pprediction = use_p2 ? predict2 : predict1;

   sat_counter2 u_sat (
      .cnt      (upd_cur),
      .inc      (taken2 & ~taken1),
      .dec      (taken1 & ~taken2),
      .cnt_next (upd_next)
   );

   // state register; ready tracks the registered state so it only moves on transitions
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         init_idx <= '0;
         ready    <= 1'b0;
      end else begin
         state <= state_next;
         ready <= (state_next == RUN);
         if (state == INIT) begin
            init_idx <= init_idx + 1'b1;
         end
      end
   end

   // leave the walk once the last entry has been written
   always_comb begin
      state_next = state;
      case (state)
         INIT:    if (init_idx == '1) state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = INIT;
      endcase
   end

   // table and counter enables; resolve traffic is ignored while the walk runs
   always_comb begin
      init_we  = (state == INIT) && !rst;
      upd_we   = (state == RUN) && !rst && upd_valid && (taken1 ^ taken2);
      miss_inc = (state == RUN) && upd_valid && !true_in && (mispredict_count != '1);
   end

   // selector table: init walk clears to weak-P1, training steps one entry
   always_ff @(posedge clk) begin
      if (init_we) begin
         sel_tbl[init_idx] <= SEL_WEAK_P1;
      end else if (upd_we) begin
         sel_tbl[upd_idx] <= upd_next;
      end
   end

   // saturating count of resolved branches whose final prediction was wrong
   always_ff @(posedge clk) begin
      if (rst) begin
         mispredict_count <= '0;
      end else if (miss_inc) begin
         mispredict_count <= mispredict_count + CNT_BITS'(1);
      end
   end

endmodule

// File: tb/tb_branch_chooser.sv
// tb/tb_branch_chooser.sv - randomized self-checking bench for branch_chooser
module tb_branch_chooser;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        predict1;
   logic        predict2;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        taken1;
   logic        taken2;
   logic        true_in;

   logic        pprediction;
   logic        use_p2;
   logic        ready;
   logic [15:0] mispredict_count;

   logic        pprediction_s;
   logic        use_p2_s;
   logic        ready_s;
   logic [1:0]  mispredict_count_s;

   int checks = 0;
   int errors = 0;

   int m_tbl [64];
   int m_cycles;
   bit m_ready;
   int m_count;
   int m_count_s;

   always #5 clk = ~clk;

   branch_chooser #(.IDX_BITS(6), .CNT_BITS(16)) dut (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict1(predict1), .predict2(predict2),
      .pprediction(pprediction), .use_p2(use_p2), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .taken1(taken1), .taken2(taken2), .true_in(true_in), .ready(ready),
      .mispredict_count(mispredict_count)
   );

   branch_chooser #(.IDX_BITS(6), .CNT_BITS(2)) dut_s (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict1(predict1), .predict2(predict2),
      .pprediction(pprediction_s), .use_p2(use_p2_s), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .taken1(taken1), .taken2(taken2), .true_in(true_in), .ready(ready_s),
      .mispredict_count(mispredict_count_s)
   );

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic logic [31:0] pc_for(input int idx);
      logic [31:0] pc;
      pc      = $urandom;
      pc[7:2] = 6'(idx);
      return pc;
   endfunction

   function automatic logic exp_use_p2();
      return m_ready && (m_tbl[idx_of(fetch_pc)] >= 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_cycles  = 0;
         m_ready   = 0;
         m_count   = 0;
         m_count_s = 0;
      end else if (!m_ready) begin
         m_cycles++;
         if (m_cycles == 64) begin
            m_ready = 1;
            foreach (m_tbl[i]) m_tbl[i] = 1;
         end
      end else if (upd_valid) begin
         int i;
         i = idx_of(upd_pc);
         if (taken2 && !taken1 && m_tbl[i] < 3) m_tbl[i]++;
         if (taken1 && !taken2 && m_tbl[i] > 0) m_tbl[i]--;
         if (!true_in) begin
            if (m_count < 65535) m_count++;
            if (m_count_s < 3) m_count_s++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; upd_valid = 1'b0; predict1 = 1'b1; predict2 = 1'b0;
      fetch_pc = 32'h0; upd_pc = 32'h0; taken1 = 1'b0; taken2 = 1'b0; true_in = 1'b1;
      repeat (3) tick();
      checks++;
      if (ready !== 1'b0 || ready_s !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %0b/%0b expected 0", ready, ready_s);
      end
      checks++;
      if (mispredict_count !== 16'd0 || mispredict_count_s !== 2'd0) begin
         errors++; $display("FAIL reset_count: got %0d/%0d expected 0", mispredict_count, mispredict_count_s);
      end
      checks++;
      if (use_p2 !== 1'b0 || pprediction !== 1'b1) begin
         errors++; $display("FAIL reset_lookup: got use_p2=%0b pred=%0b expected 0/1", use_p2, pprediction);
      end
      rst = 1'b0;
      for (int k = 0; k < 64; k++) begin
         fetch_pc = $urandom;
         #1;
         checks++;
         if (ready !== 1'b0 || use_p2 !== 1'b0 || pprediction !== 1'b1) begin
            errors++; $display("FAIL walk_cycle%0d: got ready=%0b use_p2=%0b pred=%0b expected 0/0/1", k, ready, use_p2, pprediction);
         end
         tick();
      end
      checks++;
      if (ready !== 1'b1 || ready_s !== 1'b1) begin
         errors++; $display("FAIL walk_done_ready: got %0b/%0b expected 1", ready, ready_s);
      end
      for (int k = 0; k < 64; k++) begin
         fetch_pc = pc_for(k);
         #1;
         checks++;
         if (use_p2 !== 1'b0 || pprediction !== 1'b1) begin
            errors++; $display("FAIL walk_entry%0d: got use_p2=%0b pred=%0b expected 0/1", k, use_p2, pprediction);
         end
      end
   endtask

   task automatic test_train_p2();
      upd_pc = 32'h40; upd_valid = 1'b1; taken1 = 1'b0; taken2 = 1'b1; true_in = 1'b1;
      fetch_pc = 32'h40; predict1 = 1'b0; predict2 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (use_p2 !== exp_use_p2() || use_p2 !== 1'b1) begin
            errors++; $display("FAIL train_p2_step%0d: got use_p2=%0b expected %0b", k, use_p2, exp_use_p2());
         end
      end
      upd_valid = 1'b0;
      #1;
      checks++;
      if (pprediction !== 1'b1 || use_p2 !== 1'b1) begin
         errors++; $display("FAIL train_p2_pick: got pred=%0b use_p2=%0b expected 1/1", pprediction, use_p2);
      end
      fetch_pc = 32'h44;
      #1;
      checks++;
      if (pprediction !== 1'b0 || use_p2 !== 1'b0) begin
         errors++; $display("FAIL train_p2_neighbour: got pred=%0b use_p2=%0b expected 0/0", pprediction, use_p2);
      end
   endtask

   task automatic test_train_back();
      logic exp_seq [3];
      exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0;
      upd_pc = 32'h40; fetch_pc = 32'h40; upd_valid = 1'b1; true_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         taken1 = 1'b1;
         taken2 = (k == 2);
         tick();
         checks++;
         if (use_p2 !== exp_use_p2() || use_p2 !== exp_seq[k]) begin
            errors++; $display("FAIL train_back_step%0d: got use_p2=%0b expected %0b", k, use_p2, exp_seq[k]);
         end
      end
      upd_valid = 1'b0;
   endtask

   task automatic test_bypass();
      fetch_pc = 32'h40; upd_pc = 32'h40; upd_valid = 1'b1; taken1 = 1'b0; taken2 = 1'b1;
      #1;
      checks++;
      if (use_p2 !== 1'b0) begin
         errors++; $display("FAIL bypass_same_cycle: got use_p2=%0b expected 0", use_p2);
      end
      tick();
      upd_valid = 1'b0;
      #1;
      checks++;
      if (use_p2 !== 1'b1 || use_p2 !== exp_use_p2()) begin
         errors++; $display("FAIL bypass_next_cycle: got use_p2=%0b expected 1", use_p2);
      end
   endtask

   task automatic test_mispredict();
      logic outcomes [8];
      for (int k = 0; k < 8; k++) outcomes[k] = (k >= 5);
      for (int k = 7; k > 0; k--) begin
         int j;
         logic t;
         j = int'($urandom_range(k, 0));
         t = outcomes[k]; outcomes[k] = outcomes[j]; outcomes[j] = t;
      end
      upd_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         upd_pc = pc_for(int'($urandom_range(63, 0)));
         taken1 = $urandom; taken2 = $urandom; true_in = outcomes[k];
         tick();
      end
      upd_valid = 1'b0;
      #1;
      checks++;
      if (mispredict_count !== 16'd5 || mispredict_count !== 16'(m_count)) begin
         errors++; $display("FAIL miss_count: got %0d expected 5", mispredict_count);
      end
      checks++;
      if (mispredict_count_s !== 2'd3) begin
         errors++; $display("FAIL miss_count_sat5: got %0d expected 3", mispredict_count_s);
      end
      upd_valid = 1'b1; true_in = 1'b0; upd_pc = 32'h100;
      tick();
      upd_valid = 1'b0;
      #1;
      checks++;
      if (mispredict_count !== 16'd6 || mispredict_count_s !== 2'd3) begin
         errors++; $display("FAIL miss_count_sat6: got %0d/%0d expected 6/3", mispredict_count, mispredict_count_s);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         fetch_pc  = pc_for(int'($urandom_range(7, 0)));
         upd_pc    = pc_for(int'($urandom_range(7, 0)));
         predict1  = $urandom; predict2 = $urandom;
         upd_valid = ($urandom_range(3, 0) != 0);
         taken1    = $urandom; taken2 = $urandom; true_in = $urandom;
         #1;
         checks++;
         if (use_p2 !== exp_use_p2() ||
             pprediction !== (exp_use_p2() ? predict2 : predict1) ||
             mispredict_count !== 16'(m_count) || mispredict_count_s !== 2'(m_count_s)) begin
            errors++;
            $display("FAIL random_cycle%0d: got use_p2=%0b pred=%0b cnt=%0d cnt_s=%0d expected %0b/%0b/%0d/%0d",
                     k, use_p2, pprediction, mispredict_count, mispredict_count_s,
                     exp_use_p2(), exp_use_p2() ? predict2 : predict1, m_count, m_count_s);
         end
         tick();
      end
      upd_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      checks++;
      if (mispredict_count === 16'd0) begin
         errors++; $display("FAIL mid_precount: got %0d expected nonzero", mispredict_count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (mispredict_count !== 16'd0 || mispredict_count_s !== 2'd0 || ready !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got cnt=%0d cnt_s=%0d ready=%0b expected 0/0/0", mispredict_count, mispredict_count_s, ready);
      end
      upd_valid = 1'b1; true_in = 1'b0; taken1 = 1'b0; taken2 = 1'b1;
      for (int k = 0; k < 30; k++) begin
         upd_pc = pc_for(int'($urandom_range(7, 0)));
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 64; k++) begin
         upd_pc    = pc_for(int'($urandom_range(7, 0)));
         upd_valid = $urandom;
         fetch_pc  = pc_for(int'($urandom_range(7, 0)));
         #1;
         checks++;
         if (ready !== 1'b0 || mispredict_count !== 16'd0 || use_p2 !== 1'b0) begin
            errors++; $display("FAIL rewalk_cycle%0d: got ready=%0b cnt=%0d use_p2=%0b expected 0/0/0", k, ready, mispredict_count, use_p2);
         end
         tick();
      end
      upd_valid = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1 || mispredict_count !== 16'd0) begin
         errors++; $display("FAIL rewalk_done: got ready=%0b cnt=%0d expected 1/0", ready, mispredict_count);
      end
      for (int k = 0; k < 64; k++) begin
         fetch_pc = pc_for(k);
         #1;
         checks++;
         if (use_p2 !== 1'b0 || use_p2 !== exp_use_p2()) begin
            errors++; $display("FAIL rewalk_entry%0d: got use_p2=%0b expected 0", k, use_p2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_train_p2();
      test_train_back();
      test_bypass();
      test_mispredict();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
